// File: rtl/sdram_host_queue.sv
// sdram_host_queue
//   Host-side request queue in front of sdram_controller. Host requests are
//   buffered in a small FIFO and handed to the controller one at a time on
//   rd_enable / wr_enable, waiting for the controller's busy handshake. Read
//   data returns to the host as a single-cycle rsp_valid pulse.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   req_valid/req_ready        host push handshake (req_ready = !full)
//   req_we/req_addr/req_wdata  request: 1=write, 24-bit word address, 16-bit data
//   rsp_valid/rsp_rdata/rsp_err  read response pulse; rsp_err marks an ack timeout
//   fifo_level                 queued entries, 0..DEPTH
//   timeout_err                sticky ack-timeout flag, cleared only by rst
//   haddr/data_input           controller address/data, held from ISSUE until IDLE
//   rd_enable/wr_enable        controller command strobes
//   busy/data_output           controller status and read data
//
// FSM states
//   state       | meaning
//   S_IDLE      | no request outstanding; pops the FIFO head when busy is low
//   S_ISSUE     | enable asserted, waiting for busy=1 or ack timeout
//   S_WAIT_DONE | controller accepted; waiting for busy to fall
module sdram_host_queue #(
  parameter int DEPTH       = 4,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [23:0]              req_addr,
  input  logic [15:0]              req_wdata,
  output logic                     rsp_valid,
  output logic [15:0]              rsp_rdata,
  output logic                     rsp_err,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     timeout_err,
  output logic [23:0]              haddr,
  output logic [15:0]              data_input,
  output logic                     rd_enable,
  output logic                     wr_enable,
  input  logic                     busy,
  input  logic [15:0]              data_output
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
  localparam int ENT_W = 1 + 24 + 16;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] ack_cnt_q, ack_cnt_d;

  logic        cur_we_q, cur_we_d;
  logic [23:0] haddr_q, haddr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [15:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic        timeout_err_q, timeout_err_d;

  logic             full, empty, push, pop;
  logic             ack_tc, ack_timeout, done;
  logic [ENT_W-1:0] head;
  logic             head_we;
  logic [23:0]      head_addr;
  logic [15:0]      head_wdata;

  assign full  = (count_q == LVL_W'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = req_valid && !full;
  // Popping only from IDLE keeps exactly one request outstanding; a high busy
  // (e.g. controller still initialising) holds requests in the queue.
  assign pop   = (state_q == S_IDLE) && !empty && !busy;

  assign head       = mem_q[rd_ptr_q];
  assign head_we    = head[ENT_W-1];
  assign head_addr  = head[39:16];
  assign head_wdata = head[15:0];

  // Counter runs 0..ACK_TIMEOUT-1, giving ACK_TIMEOUT cycles of enable.
  assign ack_tc      = (ack_cnt_q == CNT_W'(ACK_TIMEOUT - 1));
  assign ack_timeout = (state_q == S_ISSUE) && !busy && ack_tc;
  assign done        = (state_q == S_WAIT_DONE) && !busy;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {req_we, req_addr, req_wdata};
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + LVL_W'(1);
      2'b01:   count_d = count_q - LVL_W'(1);
      default: count_d = count_q;
    endcase
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (pop) state_d = S_ISSUE;
      S_ISSUE: begin
        if (busy)        state_d = S_WAIT_DONE;
        else if (ack_tc) state_d = S_IDLE;
      end
      S_WAIT_DONE: if (!busy) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    rd_enable = 1'b0;
    wr_enable = 1'b0;
    if (state_q == S_ISSUE) begin
      rd_enable = !cur_we_q;
      wr_enable = cur_we_q;
    end
  end

  always_comb begin
    cur_we_d      = cur_we_q;
    haddr_d       = haddr_q;
    wdata_d       = wdata_q;
    ack_cnt_d     = '0;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = '0;
    rsp_err_d     = 1'b0;
    timeout_err_d = timeout_err_q | ack_timeout;

    if (pop) begin
      cur_we_d = head_we;
      haddr_d  = head_addr;
      wdata_d  = head_wdata;
    end

    if ((state_q == S_ISSUE) && !busy && !ack_tc) begin
      ack_cnt_d = ack_cnt_q + CNT_W'(1);
    end

    if (ack_timeout && !cur_we_q) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = 1'b1;
    end else if (done && !cur_we_q) begin
      rsp_valid_d = 1'b1;
      rsp_rdata_d = data_output;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      ack_cnt_q     <= '0;
      cur_we_q      <= 1'b0;
      haddr_q       <= '0;
      wdata_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      ack_cnt_q     <= ack_cnt_d;
      cur_we_q      <= cur_we_d;
      haddr_q       <= haddr_d;
      wdata_q       <= wdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign req_ready   = !full;
  assign fifo_level  = count_q;
  assign haddr       = haddr_q;
  assign data_input  = wdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign timeout_err = timeout_err_q;

endmodule
